cva6_hpdcache_req_arbiter: RTL and testbench

// - Sits between the CVA6-side HPDcache interface adapters (load, store/AMO, PTW) and the

---
 rtl/cva6_hpdcache_req_arbiter_if.sv | 65 ++++++
 rtl/cva6_hpdcache_req_arbiter.sv | 115 +++++++++++
 tb/tb_cva6_hpdcache_req_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cva6_hpdcache_req_arbiter_if.sv
// Bundle between the CVA6 request adapters, the arbiter and the HPDcache request port.
// Signal suffixes follow the arbiter's point of view (slave modport = arbiter side).
interface cva6_hpdcache_req_arbiter_if #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned SID_W = 3
);
  typedef struct packed {
    logic [11:0]      addr_offset;
    logic [63:0]      wdata;
    logic [4:0]       op;
    logic [7:0]       be;
    logic [2:0]       size;
    logic [SID_W-1:0] sid;
    logic [7:0]       tid;
    logic             need_rsp;
  } req_t;

  typedef logic [31:0] tag_t;

  typedef struct packed {
    logic uncacheable;
    logic io;
  } pma_t;

  typedef struct packed {
    logic [63:0]      rdata;
    logic [SID_W-1:0] sid;
    logic [7:0]       tid;
    logic             error;
  } rsp_t;

  logic [NREQ-1:0] core_req_valid_i;
  logic [NREQ-1:0] core_req_ready_o;
  req_t            core_req_i       [NREQ];
  logic [NREQ-1:0] core_req_abort_i;
  tag_t            core_req_tag_i   [NREQ];
  pma_t            core_req_pma_i   [NREQ];
  logic [NREQ-1:0] core_rsp_valid_o;
  rsp_t            core_rsp_o;

  logic            dcache_req_valid_o;
  logic            dcache_req_ready_i;
  req_t            dcache_req_o;
  logic            dcache_req_abort_o;
  tag_t            dcache_req_tag_o;
  pma_t            dcache_req_pma_o;
  logic            dcache_rsp_valid_i;
  rsp_t            dcache_rsp_i;

  modport slave (
    input  core_req_valid_i, core_req_i, core_req_abort_i, core_req_tag_i, core_req_pma_i,
    input  dcache_req_ready_i, dcache_rsp_valid_i, dcache_rsp_i,
    output core_req_ready_o, core_rsp_valid_o, core_rsp_o,
    output dcache_req_valid_o, dcache_req_o, dcache_req_abort_o, dcache_req_tag_o,
    output dcache_req_pma_o
  );

  modport master (
    output core_req_valid_i, core_req_i, core_req_abort_i, core_req_tag_i, core_req_pma_i,
    output dcache_req_ready_i, dcache_rsp_valid_i, dcache_rsp_i,
    input  core_req_ready_o, core_rsp_valid_o, core_rsp_o,
    input  dcache_req_valid_o, dcache_req_o, dcache_req_abort_o, dcache_req_tag_o,
    input  dcache_req_pma_o
  );
endinterface

// File: rtl/cva6_hpdcache_req_arbiter.sv
// Locked round-robin arbiter of NREQ requesters onto the HPDcache request port, with
// second-phase sideband forwarding and sid-based response routing.
// Define CVA6_HPDCACHE_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest).
module cva6_hpdcache_req_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned SID_W = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  cva6_hpdcache_req_arbiter_if.slave         bus_io
);
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            ph2_vld_q, ph2_vld_d;
  logic [IdxW-1:0] ph2_idx_q, ph2_idx_d;
  logic [IdxW-1:0] sel;
  logic            req_valid;
  logic            hs;
`ifndef CVA6_HPDCACHE_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] rr_q, rr_d;
`endif

  // A held lock keeps the grant even if the scan would now pick another port.
  always_comb begin
    logic [IdxW:0] cand;
    logic          found;
    sel   = lock_idx_q;
    cand  = '0;
    found = 1'b0;
    if (!lock_q) begin
      sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef CVA6_HPDCACHE_ARB_FIXED_PRIO_EN
        cand = (IdxW+1)'(i);
`else
        cand = {1'b0, rr_q} + (IdxW+1)'(i);
        if (cand >= (IdxW+1)'(NREQ)) cand = cand - (IdxW+1)'(NREQ);
`endif
        if (!found && bus_io.core_req_valid_i[cand[IdxW-1:0]]) begin
          sel   = cand[IdxW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  assign req_valid = (|bus_io.core_req_valid_i) | lock_q;
  assign hs        = req_valid & bus_io.dcache_req_ready_i;

  always_comb begin
    bus_io.dcache_req_valid_o    = req_valid;
    bus_io.dcache_req_o          = bus_io.core_req_i[sel];
    bus_io.core_req_ready_o      = '0;
    bus_io.core_req_ready_o[sel] = hs;
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    ph2_vld_d  = hs;
    ph2_idx_d  = hs ? sel : ph2_idx_q;
    if (hs) begin
      lock_d = 1'b0;
    end else if (req_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
  end

`ifndef CVA6_HPDCACHE_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_d = rr_q;
    if (hs) rr_d = (sel == IdxW'(NREQ - 1)) ? '0 : sel + IdxW'(1);
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      ph2_vld_q  <= 1'b0;
      ph2_idx_q  <= '0;
`ifndef CVA6_HPDCACHE_ARB_FIXED_PRIO_EN
      rr_q       <= '0;
`endif
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      ph2_vld_q  <= ph2_vld_d;
      ph2_idx_q  <= ph2_idx_d;
`ifndef CVA6_HPDCACHE_ARB_FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // Sideband of a request arrives the cycle after its handshake.
  assign bus_io.dcache_req_abort_o = ph2_vld_q & bus_io.core_req_abort_i[ph2_idx_q];
  assign bus_io.dcache_req_tag_o   = ph2_vld_q ? bus_io.core_req_tag_i[ph2_idx_q] : '0;
  assign bus_io.dcache_req_pma_o   = ph2_vld_q ? bus_io.core_req_pma_i[ph2_idx_q] : '0;

  assign bus_io.core_rsp_o = bus_io.dcache_rsp_i;

  for (genvar k = 0; k < NREQ; k++) begin : g_rsp
    assign bus_io.core_rsp_valid_o[k] = bus_io.dcache_rsp_valid_i &
                                        (bus_io.dcache_rsp_i.sid == SID_W'(k));
  end

  sid_in_range_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus_io.dcache_rsp_valid_i |-> (32'(bus_io.dcache_rsp_i.sid) < NREQ))
    else $warning("cva6_hpdcache_req_arbiter: response sid %0d out of range, dropped",
                  bus_io.dcache_rsp_i.sid);
endmodule

// File: tb/tb_cva6_hpdcache_req_arbiter.sv
// Directed bench for cva6_hpdcache_req_arbiter: expected grants are queued when stimulus is
// driven and popped on each observed handshake.
module tb_cva6_hpdcache_req_arbiter;
`ifdef CVA6_HPDCACHE_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  cva6_hpdcache_req_arbiter_if #(.NREQ(3), .SID_W(3)) bus ();

  cva6_hpdcache_req_arbiter #(.NREQ(3), .SID_W(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample_sb();
    int unsigned g;
    if (bus.dcache_req_valid_o === 1'b1 && bus.dcache_req_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_grant", 64'(bus.core_req_ready_o), 64'd0);
      end else begin
        g = exp_q.pop_front();
        chk("grant_ready_onehot", 64'(bus.core_req_ready_o), 64'(1) << g);
        chk("grant_payload_tid", 64'(bus.dcache_req_o.tid), 64'(8'hA0 + g));
      end
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic fin();
    sample_sb();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    mid();
    fin();
  endtask

  initial begin
    rst_n                  = 1'b0;
    bus.core_req_valid_i   = '0;
    bus.core_req_abort_i   = '0;
    bus.dcache_req_ready_i = 1'b0;
    bus.dcache_rsp_valid_i = 1'b0;
    bus.dcache_rsp_i       = '0;
    for (int k = 0; k < 3; k++) begin
      bus.core_req_i[k]     = '0;
      bus.core_req_i[k].tid = 8'(8'hA0 + k);
      bus.core_req_tag_i[k] = '0;
      bus.core_req_pma_i[k] = '0;
    end

    // Reset state
    mid();
    chk("rst_ready_o", 64'(bus.core_req_ready_o), 64'd0);
    chk("rst_dcache_valid", 64'(bus.dcache_req_valid_o), 64'd0);
    chk("rst_abort_o", 64'(bus.dcache_req_abort_o), 64'd0);
    chk("rst_rsp_valid", 64'(bus.core_rsp_valid_o), 64'd0);
    chk("rst_tag_o", 64'(bus.dcache_req_tag_o), 64'd0);
    fin();
    rst_n = 1'b1;
    tick();

    // All three ports valid, ready high: rotation 0,1,2,0,1,2
    bus.core_req_valid_i   = 3'b111;
    bus.dcache_req_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(FixedPrio ? 0 : i % 3);
      tick();
    end
    bus.core_req_valid_i = 3'b000;
    tick();

    // Stall on port 1, port 0 joins while the grant is locked
    bus.core_req_valid_i   = 3'b010;
    bus.dcache_req_ready_i = 1'b0;
    mid();
    chk("lock_c1_tid", 64'(bus.dcache_req_o.tid), 64'hA1);
    chk("lock_c1_ready_o", 64'(bus.core_req_ready_o), 64'd0);
    chk("lock_c1_valid_o", 64'(bus.dcache_req_valid_o), 64'd1);
    fin();
    bus.core_req_valid_i = 3'b011;
    mid();
    chk("lock_c2_tid", 64'(bus.dcache_req_o.tid), 64'hA1);
    chk("lock_c2_ready_o", 64'(bus.core_req_ready_o), 64'd0);
    fin();
    mid();
    chk("lock_c3_tid", 64'(bus.dcache_req_o.tid), 64'hA1);
    fin();
    bus.dcache_req_ready_i = 1'b1;
    exp_q.push_back(1);
    tick();
    bus.core_req_valid_i = 3'b001;
    exp_q.push_back(0);
    tick();

    // Phase-2 sideband; this cycle also carries phase 2 of the port 0 handshake
    bus.core_req_tag_i[0]   = 32'hDEAD;
    bus.core_req_tag_i[1]   = 32'h5555;
    bus.core_req_tag_i[2]   = 32'h1234;
    bus.core_req_abort_i    = 3'b011;
    bus.core_req_pma_i[0]   = 2'b01;
    bus.core_req_pma_i[2]   = 2'b10;
    bus.core_req_valid_i    = 3'b100;
    exp_q.push_back(2);
    mid();
    chk("b2b_ph2_abort", 64'(bus.dcache_req_abort_o), 64'd1);
    chk("b2b_ph2_tag", 64'(bus.dcache_req_tag_o), 64'hDEAD);
    fin();
    bus.core_req_valid_i = 3'b000;
    mid();
    chk("ph2_p2_tag", 64'(bus.dcache_req_tag_o), 64'h1234);
    chk("ph2_p2_abort", 64'(bus.dcache_req_abort_o), 64'd0);
    chk("ph2_p2_pma", 64'(bus.dcache_req_pma_o), 64'h2);
    fin();
    bus.core_req_valid_i = 3'b001;
    exp_q.push_back(0);
    mid();
    chk("ph2_idle_tag", 64'(bus.dcache_req_tag_o), 64'd0);
    chk("ph2_idle_abort", 64'(bus.dcache_req_abort_o), 64'd0);
    fin();
    bus.core_req_valid_i = 3'b000;
    mid();
    chk("ph2_p0_abort", 64'(bus.dcache_req_abort_o), 64'd1);
    chk("ph2_p0_tag", 64'(bus.dcache_req_tag_o), 64'hDEAD);
    fin();

    // Response routing, with a simultaneous handshake on port 1
    bus.core_req_valid_i         = 3'b010;
    bus.dcache_rsp_valid_i       = 1'b1;
    bus.dcache_rsp_i.sid         = 3'd1;
    bus.dcache_rsp_i.rdata       = 64'hCAFE_F00D_0000_0001;
    exp_q.push_back(1);
    mid();
    chk("rsp_sid1_valid", 64'(bus.core_rsp_valid_o), 64'b010);
    chk("rsp_sid1_rdata", bus.core_rsp_o.rdata, 64'hCAFE_F00D_0000_0001);
    fin();
    bus.core_req_valid_i = 3'b000;
    bus.dcache_rsp_i.sid = 3'd0;
    mid();
    chk("rsp_sid0_valid", 64'(bus.core_rsp_valid_o), 64'b001);
    fin();
    bus.dcache_rsp_i.sid = 3'd2;
    mid();
    chk("rsp_sid2_valid", 64'(bus.core_rsp_valid_o), 64'b100);
    fin();
    bus.dcache_rsp_i.sid = 3'd3;
    mid();
    chk("rsp_sid3_dropped", 64'(bus.core_rsp_valid_o), 64'b000);
    fin();
    bus.dcache_rsp_valid_i = 1'b0;
    bus.dcache_rsp_i.sid   = 3'd1;
    mid();
    chk("rsp_novalid", 64'(bus.core_rsp_valid_o), 64'b000);
    fin();

    // Lock a grant, then reset mid-stall
    bus.core_req_valid_i   = 3'b110;
    bus.dcache_req_ready_i = 1'b0;
    mid();
    chk("pre_rst_lock_tid", 64'(bus.dcache_req_o.tid), 64'(FixedPrio ? 8'hA1 : 8'hA2));
    fin();
    mid();
    chk("pre_rst_held_tid", 64'(bus.dcache_req_o.tid), 64'(FixedPrio ? 8'hA1 : 8'hA2));
    fin();
    rst_n                  = 1'b0;
    bus.core_req_valid_i   = 3'b000;
    bus.dcache_req_ready_i = 1'b1;
    mid();
    chk("in_rst_ready_o", 64'(bus.core_req_ready_o), 64'd0);
    chk("in_rst_valid_o", 64'(bus.dcache_req_valid_o), 64'd0);
    chk("in_rst_abort_o", 64'(bus.dcache_req_abort_o), 64'd0);
    fin();
    rst_n = 1'b1;
    mid();
    chk("post_rst_ready_o", 64'(bus.core_req_ready_o), 64'd0);
    fin();
    bus.core_req_valid_i = 3'b110;
    exp_q.push_back(1);
    tick();
    exp_q.push_back(FixedPrio ? 1 : 2);
    tick();

    // Ports 0 and 2 continuously valid
    bus.core_req_valid_i = 3'b101;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((FixedPrio || (i % 2 == 0)) ? 0 : 2);
      tick();
    end
    bus.core_req_valid_i = 3'b000;
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
